// File: rtl/hash_stream_serializer.sv
// Buffers SHA-256 digests in a DEPTH-entry FIFO and serializes each as OUT_WIDTH-bit beats, MSW first.
// Latency: one cycle from push to beat 0 when empty. Backpressure: out_ready stalls beats; a push to a full FIFO is dropped.
// Optional: define HASH_STREAM_DROP_COUNT_EN to add a saturating 16-bit drop_count output.
module hash_stream_serializer #(
  parameter int DEPTH     = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [255:0]                 hash,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef HASH_STREAM_DROP_COUNT_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  localparam int BEATS = 256 / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef enum logic {S_EMPTY, S_SENDING} state_t;

  state_t        state, state_nxt;
  logic [255:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [BW-1:0] beat;
  logic [255:0]  head;
  logic          beat_end, xfer, pop_last, full, push, drop;

  assign beat_end = (beat == BW'(BEATS - 1));
  assign xfer     = out_valid & out_ready;
  assign pop_last = xfer & out_last;
  assign full     = (count == LW'(DEPTH));
  // A slot freed by the head's final beat can be reused in the same cycle.
  assign push     = in_valid & (~full | pop_last);
  assign drop     = in_valid & full & ~pop_last;
  assign head     = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hash;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (xfer) begin
        if (beat_end) begin
          beat   <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (push && !pop_last)      count <= count + 1'b1;
      else if (!push && pop_last) count <= count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:   if (push) state_nxt = S_SENDING;
      S_SENDING: if (pop_last && !push && count == LW'(1)) state_nxt = S_EMPTY;
      default:   state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == S_SENDING);
    out_last  = out_valid & beat_end;
    out_data  = '0;
    if (out_valid) out_data = head[(BEATS - 1 - int'(beat)) * OUT_WIDTH +: OUT_WIDTH];
  end

`ifdef HASH_STREAM_DROP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_count <= '0;
    else if (drop && drop_count != '1)  drop_count <= drop_count + 16'd1;
  end
  assign overflow = (drop_count != '0);
`else
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`endif

endmodule

// File: doc/hash_stream_serializer.md
Name: hash_stream_serializer

Overview:
- Sits directly downstream of the pipelined SHA-256 core and consumes its output pair (out_valid, 256-bit hash).
- The core cannot stall, so this block buffers finished hashes in a small FIFO. It then emits each hash as OUT_WIDTH-bit beats on a valid/ready stream with a last flag.
- Hashes that arrive while the buffer is full are dropped and flagged.

Parameters:
- DEPTH, 4: number of 256-bit hash entries buffered; power of two, >= 2.
- OUT_WIDTH, 32: output beat width; must divide 256. BEATS = 256/OUT_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  hash qualifier, driven from the core's out_valid.
- hash  input  256  finished digest, big-endian (h0 in [255:224]).
- out_data  output  OUT_WIDTH  current beat of the head hash.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  current beat is the final beat of its hash.
- overflow  output  1  sticky; a hash was dropped.
- level  output  $clog2(DEPTH+1)  entries stored, including one partially sent.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, write/read pointers = 0, beat = 0, overflow = 0.
  - Therefore out_valid = 0, out_last = 0, level = 0. out_data is driven as 0 while out_valid is low.
- Push:
  - Condition: in_valid = 1 AND (count < DEPTH OR pop_last).
  - pop_last = out_valid & out_ready & out_last in the same cycle.
  - On push, hash is written at the write pointer, which then wraps modulo DEPTH.
- Drop:
  - Condition: in_valid = 1, count = DEPTH, and no pop_last that cycle.
  - The hash is discarded. overflow is set to 1 and held until reset.
  - The FIFO contents are not modified.
- Pop:
  - A beat transfers when out_valid & out_ready.
  - beat increments; at beat = BEATS-1 it wraps to 0, the read pointer advances modulo DEPTH, and count decrements.
- Simultaneous push and pop_last: count is unchanged; both pointers advance.
- Serialization order: beat k carries hash[255-k*OUT_WIDTH -: OUT_WIDTH], i.e. most-significant word first.
- State view:
  - EMPTY: count = 0, out_valid = 0.
  - SENDING: count > 0, out_valid = 1, beat indexes the head entry.
  - SENDING -> EMPTY when pop_last occurs with count = 1 and no push.
  - EMPTY -> SENDING on any push.
- Output timing:
  - out_data, out_last and out_valid derive from registered state only. There is no combinational path from in_valid, hash or out_ready to any output.
  - out_last = out_valid & (beat == BEATS-1).
- Latency: a hash pushed at edge N is visible on out_data (beat 0, out_valid = 1) in the cycle after edge N, provided the FIFO was empty.
- Stream rule: once out_valid = 1, out_data and out_last hold stable until accepted. out_valid never drops without a transfer, except on reset.
- level = count.
- Reset mid-transfer: the partially sent hash and all buffered hashes are discarded. Outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: HASH_STREAM_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count (16 bits), which increments on every drop event and saturates at 16'hFFFF.
  - drop_count is reset to 0 by rst_n.
  - overflow behaves as above, and equals (drop_count != 0).
- Undefined: the port and counter are absent; only the sticky overflow flag exists.

Test Plan:
- Single hash, out_ready = 1 held: push 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad -> cycles 1..8 after the push show out_data = ba7816bf, 8f01cfea, ..., f20015ad; out_last = 1 only on f20015ad; then out_valid = 0 and level = 0.
- Backpressure: out_ready toggles 1,0,0,1,... -> every beat appears exactly once, in order; out_data stays stable while out_ready = 0; the stream completes in 8 accepted beats.
- Fill and overflow (DEPTH = 4, out_ready = 0): push 5 distinct hashes on consecutive cycles -> level = 4 and overflow = 1 after the 5th. Releasing out_ready drains exactly the first 4 hashes (32 beats); the 5th is never emitted. With the macro defined, drop_count = 1.
- Push on full with pop_last: FIFO full, out_ready = 1, and in_valid asserted in the same cycle as the final beat of the head -> no drop, overflow stays 0, level stays 4, and the new hash is emitted last.
- Back-to-back: in_valid = 1 for 3 consecutive cycles with out_ready = 1 -> 24 contiguous beats with no gaps; out_last on beats 8, 16 and 24; level peaks at 3.
- Reset mid-stream: assert rst_n = 0 at beat 3 of the 2nd of 3 buffered hashes -> out_valid, level and overflow go to 0 immediately. After release, a new push emits beat 0 of the new hash, with no stale data.
